// File: rtl/qs_srt_ucode_loader_if.sv
// Instruction encoding shared with the ucode decoder, and the host instruction stream interface.
package qs_srt_pkg;

   typedef enum logic [3:0] {
      NOP   = 4'd0,
      JCC   = 4'd1,
      PP    = 4'd2,
      MEM   = 4'd3,
      MOV   = 4'd4,
      ARITH = 4'd5,
      CRET  = 4'd6,
      CNTRL = 4'd7
   } opcode_e;

   // Opcode kept as a raw field so a host can present encodings the decoder would reject.
   typedef struct packed {
      logic [3:0]  opcode;
      logic [11:0] operand;
   } inst_t;

endpackage

interface qs_srt_ucode_loader_if;
   logic              in_vld;
   qs_srt_pkg::inst_t in_inst;
   logic              in_rdy;

   modport master (output in_vld, output in_inst, input  in_rdy);
   modport slave  (input  in_vld, input  in_inst, output in_rdy);
endinterface

// File: rtl/qs_srt_ucode_loader.sv
// Ucode store writer: streams host instruction words into consecutive RAM addresses,
// rejecting illegal opcodes and holding fetch off (busy) while the image is written.
module qs_srt_ucode_loader #(
   parameter int unsigned ADDR_W       = 8,
   parameter bit          CHECK_OPCODE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_start,
   input  logic [ADDR_W-1:0]     cfg_base_addr,
   input  logic [ADDR_W:0]       cfg_len,
   qs_srt_ucode_loader_if.slave  host,
   output logic                  ucode_wr_en,
   output logic [ADDR_W-1:0]     ucode_wr_addr,
   output qs_srt_pkg::inst_t     ucode_wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_W-1:0]     err_addr
);
   import qs_srt_pkg::*;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   remaining_q;
   logic              beat;
   logic              legal;
   logic              last_beat;

   assign host.in_rdy = (state_q == LOAD);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign beat        = host.in_vld && (state_q == LOAD);
   assign last_beat   = (remaining_q == (ADDR_W+1)'(1));

   always_comb begin
      legal = 1'b1;
      if (CHECK_OPCODE) begin
         case (host.in_inst.opcode)
            NOP, JCC, PP, MEM, MOV, ARITH, CRET, CNTRL: legal = 1'b1;
            default:                                    legal = 1'b0;
         endcase
      end
   end

   // An empty load still passes through FLUSH so done lands two cycles after the start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cfg_start) state_d = (cfg_len == '0) ? FLUSH : LOAD;
         LOAD:    if (beat && (!legal || last_beat)) state_d = FLUSH;
         FLUSH:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         remaining_q   <= '0;
         ucode_wr_en   <= 1'b0;
         ucode_wr_addr <= '0;
         ucode_wr_data <= '0;
         err           <= 1'b0;
         err_addr      <= '0;
      end else begin
         state_q     <= state_d;
         ucode_wr_en <= 1'b0;
         if ((state_q == IDLE) && cfg_start) begin
            ptr_q       <= cfg_base_addr;
            remaining_q <= cfg_len;
            err         <= 1'b0;
         end
         if (beat) begin
            if (legal) begin
               ucode_wr_en   <= 1'b1;
               ucode_wr_addr <= ptr_q;
               ucode_wr_data <= host.in_inst;
               ptr_q         <= ptr_q + ADDR_W'(1);
               remaining_q   <= remaining_q - (ADDR_W+1)'(1);
            end else begin
               err      <= 1'b1;
               err_addr <= ptr_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_qs_srt_ucode_loader.sv
// Randomized bench for qs_srt_ucode_loader against a per-load reference of expected writes.
module tb_qs_srt_ucode_loader;
   import qs_srt_pkg::*;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              cfg_start = 1'b0;
   logic [ADDR_W-1:0] cfg_base_addr = '0;
   logic [ADDR_W:0]   cfg_len = '0;
   logic              ucode_wr_en, busy, done, err;
   logic [ADDR_W-1:0] ucode_wr_addr, err_addr;
   inst_t             ucode_wr_data;

   qs_srt_ucode_loader_if host_if();

   qs_srt_ucode_loader #(.ADDR_W(ADDR_W), .CHECK_OPCODE(1'b1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start     (cfg_start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_len       (cfg_len),
      .host          (host_if),
      .ucode_wr_en   (ucode_wr_en),
      .ucode_wr_addr (ucode_wr_addr),
      .ucode_wr_data (ucode_wr_data),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .err_addr      (err_addr)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      inst_t             data;
      int unsigned       cyc;
   } wr_t;

   wr_t         wr_q[$];
   int unsigned done_cnt = 0, busy_cnt = 0, rdy_cnt = 0;

   // Observe outputs on the falling edge; the driver acts 1 time unit later.
   always @(negedge clk) begin
      if (ucode_wr_en) wr_q.push_back('{ucode_wr_addr, ucode_wr_data, cyc});
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (host_if.in_rdy) rdy_cnt++;
   end

   int unsigned n_cmp = 0, n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic inst_t rand_inst(input bit illegal);
      inst_t w;
      w.opcode  = illegal ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      w.operand = 12'($urandom);
      return w;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_rdy"},   32'(host_if.in_rdy), 0);
      check({tag, "_wr_en"}, 32'(ucode_wr_en), 0);
      check({tag, "_done"},  32'(done), 0);
      check({tag, "_err"},   32'(err), 0);
      check({tag, "_waddr"}, 32'(ucode_wr_addr), 0);
      check({tag, "_wdata"}, 32'(ucode_wr_data), 0);
      check({tag, "_eaddr"}, 32'(err_addr), 0);
   endtask

   // One load: bad_idx<0 means all words legal; abort_after>=0 pulls reset after that many beats.
   task automatic run_load(input logic [ADDR_W-1:0] base, input int unsigned len,
                           input int bad_idx, input int unsigned vld_pct,
                           input bit mid_start, input int abort_after, input bit chk_lat);
      inst_t             words[$];
      logic [ADDR_W-1:0] ea;
      int unsigned       idx, start_cyc, lat, busy0, rdy0, done0, n_exp, exp_lat;
      bit                seen, bad;
      idx  = 0;
      seen = 1'b0;
      bad  = (bad_idx >= 0) && (bad_idx < int'(len));
      for (int i = 0; i < int'(len); i++) words.push_back(rand_inst(i == bad_idx));
      n_exp = bad ? int'(bad_idx) : len;
      wr_q.delete();

      @(negedge clk); #1;
      cfg_start     = 1'b1;
      cfg_base_addr = base;
      cfg_len       = (ADDR_W+1)'(len);
      start_cyc     = cyc;
      busy0 = busy_cnt; rdy0 = rdy_cnt; done0 = done_cnt;

      for (int c = 0; c < 5000 && !seen; c++) begin
         @(negedge clk); #1;
         cfg_start      = 1'b0;
         host_if.in_vld = 1'b0;
         if (c == 0) begin
            check("busy_after_start", 32'(busy), 1);
            check("err_cleared_on_start", 32'(err), 0);
         end
         if (done) begin
            seen = 1'b1;
         end else if (abort_after >= 0 && idx == abort_after) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("async_reset");
            @(negedge clk); #1;
            rst_n = 1'b1;
            check("abort_write_count", wr_q.size(), abort_after);
            for (int i = 0; i < abort_after && i < wr_q.size(); i++) begin
               ea = ADDR_W'(base + i);
               check("abort_write_addr", 32'(wr_q[i].addr), 32'(ea));
               check("abort_write_data", 32'(wr_q[i].data), 32'(words[i]));
            end
            repeat (3) @(negedge clk);
            #1;
            check("abort_no_done", done_cnt - done0, 0);
            check("abort_idle", 32'(busy), 0);
            return;
         end else begin
            if (mid_start && host_if.in_rdy && $urandom_range(0, 7) == 0) begin
               cfg_start     = 1'b1;
               cfg_base_addr = ADDR_W'($urandom);
               cfg_len       = (ADDR_W+1)'($urandom_range(0, DEPTH));
            end
            if (idx < len && $urandom_range(1, 100) <= vld_pct) begin
               host_if.in_vld  = 1'b1;
               host_if.in_inst = words[idx];
               if (host_if.in_rdy) idx++;
            end
         end
      end

      if (!seen) check("done_timeout", 0, 1);
      lat = cyc - start_cyc;
      if (chk_lat) begin
         exp_lat = (len == 0) ? 2 : (bad ? int'(bad_idx) + 3 : len + 2);
         check("done_latency", lat, exp_lat);
      end
      check("busy_cycles", busy_cnt - busy0, lat);
      check("rdy_cycles", rdy_cnt - rdy0, lat - 2);
      check("done_pulses", done_cnt - done0, 1);
      check("err_flag", 32'(err), 32'(bad));
      if (bad) begin
         ea = ADDR_W'(base + bad_idx);
         check("err_addr", 32'(err_addr), 32'(ea));
      end
      check("write_count", wr_q.size(), n_exp);
      for (int i = 0; i < int'(n_exp) && i < wr_q.size(); i++) begin
         ea = ADDR_W'(base + i);
         check("write_addr", 32'(wr_q[i].addr), 32'(ea));
         check("write_data", 32'(wr_q[i].data), 32'(words[i]));
         if (chk_lat) check("write_cycle", wr_q[i].cyc - start_cyc, 2 + i);
      end

      @(negedge clk); #1;
      check("busy_after_done", 32'(busy), 0);
      check("rdy_after_done", 32'(host_if.in_rdy), 0);
      check("done_single", 32'(done), 0);
      check("no_extra_writes", wr_q.size(), n_exp);
   endtask

   initial begin
      int unsigned l;
      int          b;
      host_if.in_vld  = 1'b0;
      host_if.in_inst = '0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_load(8'h10, 4, -1, 100, 1'b0, -1, 1'b1);
      run_load(8'hFE, 4, -1, 100, 1'b0, -1, 1'b1);
      run_load(ADDR_W'($urandom), 3, 1, 100, 1'b0, -1, 1'b1);
      run_load(ADDR_W'($urandom), 0, -1, 100, 1'b0, -1, 1'b1);

      for (int k = 0; k < 8; k++) begin
         l = $urandom_range(1, 20);
         b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, l - 1)) : -1;
         run_load(ADDR_W'($urandom), l, b, 60, 1'b1, -1, 1'b0);
      end

      run_load(8'hC3, DEPTH, -1, 80, 1'b0, -1, 1'b0);

      run_load(ADDR_W'($urandom), 5, -1, 100, 1'b0, 2, 1'b0);
      run_load(8'h40, 5, -1, 100, 1'b0, -1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
